gate_settle_sequencer: RTL and testbench

Sequencer for the 2-input gate-level evaluation cell. On `start` it drives all four input vectors in turn: {in2,in1} = 00, 01, 10, 11. For each vector it waits a programmable settle time covering the cell's worst-case gate plus fan-out delay, then samples the cell output. The result is a 4-bit truth table, compared against an expected mask to give a pass/fail. It sits between the lab testbench/top level and the combinational cell, and owns the cell's inputs.

---
 rtl/gate_seq_pkg.sv | 14 +
 rtl/settle_timer.sv | 23 ++
 rtl/gate_settle_sequencer.sv | 155 +++++++++++++++
 tb/tb_gate_settle_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types and sizes for the gate-level truth-table sweep sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;

endpackage

// File: rtl/settle_timer.sv
// Up-counter that flags the last cycle of a programmable settle window.
module settle_timer #(
  parameter int SETTLE_CYCLES = 12,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (en)   cnt_q <= cnt_q + 1'b1;
  end

  assign expire = en && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_settle_sequencer.sv
// Drives the four {in2,in1} vectors into the cell, samples each after a settle
// window and reports the captured truth table against an expected mask.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// SETTLE | vector driven, waiting for the cell to settle
// SAMPLE | one cycle; cell output captured at its closing edge
// DONE   | one cycle; done pulse, results valid
module gate_settle_sequencer
  import gate_seq_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 12,
  parameter int         CNT_W         = 8,
  parameter logic [3:0] EXPECTED      = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cell_out1,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [3:0] truth,
  output logic       pass,
  output logic [3:0] mismatch
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] drv_q, drv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic [3:0]       truth_q, truth_d;
  logic             pass_q, pass_d;
  logic [3:0]       mismatch_q, mismatch_d;
  logic             timer_clr, timer_en, expire;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .expire(expire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    drv_d      = drv_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    truth_d    = truth_q;
    pass_d     = pass_q;
    mismatch_d = mismatch_q;
    timer_clr  = 1'b0;
    timer_en   = (state_q == SETTLE);

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = SETTLE;
          idx_d     = '0;
          drv_d     = '0;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
          truth_d   = '0;
          timer_clr = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          drv_d   = '0;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else if (expire) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          drv_d   = '0;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else begin
          truth_d[idx_q] = cell_out1;
          if (idx_q != VEC_W'(NUM_VECTORS - 1)) begin
            idx_d     = idx_q + 1'b1;
            drv_d     = idx_q + 1'b1;
            state_d   = SETTLE;
            timer_clr = 1'b1;
          end else begin
            // results are registered on the same edge that captures the last bit
            state_d    = DONE;
            drv_d      = '0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            valid_d    = 1'b1;
            pass_d     = (truth_d == EXPECTED);
            mismatch_d = truth_d ^ EXPECTED;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      drv_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      truth_q    <= '0;
      pass_q     <= 1'b0;
      mismatch_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drv_q      <= drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      truth_q    <= truth_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign drv_in1  = drv_q[0];
  assign drv_in2  = drv_q[1];
  assign busy     = busy_q;
  assign done     = done_q;
  assign valid    = valid_q;
  assign truth    = truth_q;
  assign pass     = pass_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_gate_settle_sequencer.sv
// Randomized sweeps of a delayed behavioural cell; results scoreboarded at done.
`timescale 1ns/1ps
module tb_gate_settle_sequencer;

  localparam int         SETTLE   = 12;
  localparam logic [3:0] EXP_MASK = 4'hF;
  localparam int         SWEEP    = 4 * (SETTLE + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cell_out1;
  logic       drv_in1, drv_in2, busy, done, valid, pass;
  logic [3:0] truth, mismatch;

  gate_settle_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .cell_out1(cell_out1),
    .drv_in1  (drv_in1),
    .drv_in2  (drv_in2),
    .busy     (busy),
    .done     (done),
    .valid    (valid),
    .truth    (truth),
    .pass     (pass),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cell: truth-table function seen through a delay of cell_d cycles.
  logic [3:0] cell_func = 4'hF;
  int         cell_d = 0;
  logic [1:0] hist [0:31];
  logic [1:0] dvec;

  initial for (int i = 0; i < 32; i++) hist[i] = 2'b00;

  always @(posedge clk) begin
    hist[0] <= {drv_in2, drv_in1};
    for (int i = 1; i < 32; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    dvec = (cell_d == 0) ? {drv_in2, drv_in1} : hist[cell_d-1];
    cell_out1 = cell_func[dvec];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A vector is read correctly only if the cell delay fits inside its hold time;
  // otherwise the sample still reflects the previously driven vector.
  function automatic logic [3:0] ref_truth(input logic [3:0] f, input int d);
    logic [3:0] t;
    for (int v = 0; v < 4; v++) begin
      int src;
      src  = (d <= SETTLE) ? v : ((v == 0) ? 0 : v - 1);
      t[v] = f[src];
    end
    return t;
  endfunction

  typedef struct {
    int         at;
    logic [3:0] truth;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.at));
        check("truth", 32'(truth), 32'(e.truth));
        check("pass", 32'(pass), 32'(e.truth == EXP_MASK));
        check("mismatch", 32'(mismatch), 32'(e.truth ^ EXP_MASK));
        check("valid_at_done", 32'(valid), 32'd1);
      end
    end
  end

  task automatic run_sweep(input logic [3:0] f, input int d, input int abort_at, input bit repulse);
    int  e0;
    bit  aborted;
    cell_func = f;
    cell_d    = d;
    aborted   = 0;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    e0 = cyc + 1;
    if (abort_at < 0) begin
      exp_t e;
      e.at    = e0 + SWEEP;
      e.truth = ref_truth(f, d);
      sb.push_back(e);
    end
    for (int n = 0; n < SWEEP; n++) begin
      @(negedge clk);
      check("sweep_busy", 32'(busy), 32'd1);
      check("sweep_drv", 32'({drv_in2, drv_in1}), 32'(n / (SETTLE + 1)));
      if (n == 0) check("valid_cleared", 32'(valid), 32'd0);
      start = repulse && (n == 10 || n == 30);
      abort = (n == abort_at);
      if (abort) begin
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_drv", 32'({drv_in2, drv_in1}), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        aborted = 1;
        break;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      @(negedge clk);
      check("end_busy", 32'(busy), 32'd0);
      check("end_drv", 32'({drv_in2, drv_in1}), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("valid_hold", 32'(valid), 32'd1);
    end
    repeat (30) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_truth", 32'(truth), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_drv", 32'({drv_in2, drv_in1}), 32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    run_sweep(4'hF, 11, -1, 0);   // correct cell
    run_sweep(4'b1000, 3, -1, 0); // AND instead of constant 1
    run_sweep(4'b0101, 11, -1, 0);
    run_sweep(4'b0101, 20, -1, 0); // delay longer than the settle window
    run_sweep(4'hF, 5, -1, 1);    // start re-pulsed mid-sweep
    run_sweep(4'hF, 2, 20, 0);    // abort mid-sweep
    run_sweep(4'hF, 2, -1, 0);    // recovery after abort
    run_sweep(4'b0110, 4, 51, 0); // abort during the final sample

    for (int k = 0; k < 10; k++) begin
      logic [3:0] f;
      int         d, ab;
      f  = (($urandom % 3) == 0) ? 4'hF : 4'($urandom);
      d  = int'($urandom_range(0, 20));
      ab = (($urandom % 5) == 0) ? int'($urandom_range(0, SWEEP - 1)) : -1;
      run_sweep(f, d, ab, bit'($urandom % 2));
    end

    // abort and start together in IDLE: start dropped
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);

    // asynchronous reset in the middle of a sweep
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_drv", 32'({drv_in2, drv_in1}), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_truth", 32'(truth), 32'd0);
    check("arst_pass", 32'(pass), 32'd0);
    check("arst_mismatch", 32'(mismatch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    check("post_reset_idle", 32'(busy), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
